display_scan: RTL and testbench

DISPLAY_SCAN -- requirements
Module: display_scan

---
 rtl/display_scan.sv | 90 +++++++++
 tb/tb_display_scan.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan.sv
// Four-digit multiplexed display scanner: prescaled digit slots with a blanking guard,
// double-buffered value (shadow -> active at frame boundary), blank and leading-zero suppression.
module display_scan #(
  parameter int DIVIDE = 50000,
  parameter int GUARD  = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        load,
  input  logic [3:0]  blank,
  input  logic        lz_en,
  output logic [3:0]  address,
  output logic [3:0]  digit_n,
  output logic        frame_start
);

  localparam int PW = (DIVIDE > 1) ? $clog2(DIVIDE) : 1;
  localparam logic [PW-1:0] LAST    = PW'(DIVIDE - 1);
  localparam logic [PW-1:0] GUARD_P = PW'(GUARD);

  logic [PW-1:0] r_pcount;
  logic [1:0]    r_idx;
  logic [15:0]   r_shadow;
  logic [15:0]   r_active;
  logic [3:0]    r_address;
  logic          r_frame_start;
  logic          r_running;

  logic          w_slot_end;
  logic [PW-1:0] w_pcount_next;
  logic [1:0]    w_idx_next;
  logic [15:0]   w_active_next;
  logic [3:0]    w_lz_sup;
  logic [3:0]    w_suppress;

  // r_running holds the scan at pcount 0 / digit 0 for the first edge after reset,
  // so that edge opens a fresh digit-0 slot with frame_start high.
  always_comb begin
    // NOTE: every signal gets a default first, so no path through this block can infer a latch.
    w_slot_end    = r_running && (r_pcount == LAST);
    w_pcount_next = r_pcount;
    w_idx_next    = r_idx;
    w_active_next = r_active;
    if (r_running) begin
      w_pcount_next = w_slot_end ? '0 : r_pcount + 1'b1;
      if (w_slot_end) begin
        w_idx_next = r_idx + 1'b1;
        if (r_idx == 2'd3) w_active_next = r_shadow;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pcount      <= '0;
      r_idx         <= '0;
      r_shadow      <= '0;
      r_active      <= '0;
      r_address     <= '0;
      r_frame_start <= 1'b0;
      r_running     <= 1'b0;
    end else begin
      // NOTE: non-blocking updates mean a load on the frame-boundary edge writes r_shadow
      // while r_active still takes the old shadow; the new value waits for the next boundary.
      r_running     <= 1'b1;
      r_pcount      <= w_pcount_next;
      r_idx         <= w_idx_next;
      r_active      <= w_active_next;
      if (load) r_shadow <= value;
      r_address     <= w_active_next[{w_idx_next, 2'b00} +: 4];
      r_frame_start <= (w_idx_next == 2'd0) && (w_pcount_next == '0);
    end
  end

  // Digit k is a leading zero when nibbles k..3 are all zero; digit 0 always shows.
  always_comb begin
    w_lz_sup    = 4'b0000;
    w_lz_sup[3] = lz_en && (r_active[15:12] == 4'h0);
    w_lz_sup[2] = lz_en && (r_active[15:8]  == 8'h00);
    w_lz_sup[1] = lz_en && (r_active[15:4]  == 12'h000);
    w_suppress  = blank | w_lz_sup;
    digit_n     = 4'b1111;
    if ((r_pcount >= GUARD_P) && !w_suppress[r_idx]) digit_n[r_idx] = 1'b0;
  end

  assign address     = r_address;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan with DIVIDE=4, GUARD=1: 16-cycle frames, guard at pcount 0.
module tb_display_scan;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] value = '0;
  logic        load  = 1'b0;
  logic [3:0]  blank = '0;
  logic        lz_en = 1'b0;
  logic [3:0]  address;
  logic [3:0]  digit_n;
  logic        frame_start;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] obs_addr [16];
  logic [3:0] obs_dn   [16];
  logic       obs_fs   [16];

  display_scan #(.DIVIDE(4), .GUARD(1)) dut (
    .clock       (clock),
    .reset       (reset),
    .value       (value),
    .load        (load),
    .blank       (blank),
    .lz_en       (lz_en),
    .address     (address),
    .digit_n     (digit_n),
    .frame_start (frame_start)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Expected digit_n for frame cycle i given which digits should be lit.
  function automatic logic [3:0] exp_dn(int i, logic [3:0] lit);
    int s;
    s = i / 4;
    if ((i % 4) == 0 || !lit[s]) return 4'b1111;
    return ~(4'b0001 << s);
  endfunction

  // Records one frame starting at the next (or current) frame_start cycle; ends on cycle 15.
  task automatic capture_frame(input string name);
    int n;
    n = 0;
    while (frame_start !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    if (frame_start !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s frame_start_timeout: frame_start=%b after %0d cycles, expected 1", name, frame_start, n);
    end
    for (int i = 0; i < 16; i++) begin
      obs_addr[i] = address;
      obs_dn[i]   = digit_n;
      obs_fs[i]   = frame_start;
      if (i < 15) tick();
    end
  endtask

  task automatic test_reset();
    repeat (2) tick();
    n_tests++;
    if (address !== 4'h0 || digit_n !== 4'b1111 || frame_start !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: addr=%h dn=%b fs=%b, expected addr=0 dn=1111 fs=0", address, digit_n, frame_start);
    end
    reset = 1'b0;
    tick();
    n_tests++;
    if (address !== 4'h0 || digit_n !== 4'b1111 || frame_start !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_cycle: addr=%h dn=%b fs=%b, expected addr=0 dn=1111 fs=1", address, digit_n, frame_start);
    end
    tick();
    n_tests++;
    if (address !== 4'h0 || digit_n !== 4'b1110 || frame_start !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_second_cycle: addr=%h dn=%b fs=%b, expected addr=0 dn=1110 fs=0", address, digit_n, frame_start);
    end
  endtask

  task automatic test_basic();
    logic [15:0] ev;
    logic [3:0] ea, ed;
    ev = 16'h1234;
    value = ev; load = 1'b1;
    tick();
    load = 1'b0;
    capture_frame("basic");
    for (int i = 0; i < 16; i++) begin
      ea = ev[(i/4)*4 +: 4];
      ed = exp_dn(i, 4'b1111);
      n_tests++;
      if (obs_addr[i] !== ea || obs_dn[i] !== ed || obs_fs[i] !== (i == 0)) begin
        n_fail++;
        $display("FAIL basic cyc%0d: addr=%h dn=%b fs=%b, expected addr=%h dn=%b fs=%b", i, obs_addr[i], obs_dn[i], obs_fs[i], ea, ed, i == 0);
      end
    end
  endtask

  task automatic test_leading_zero();
    logic [15:0] ev;
    logic [3:0] ea, ed;
    lz_en = 1'b1;
    ev = 16'h0050;
    tick();
    value = ev; load = 1'b1;
    tick();
    load = 1'b0;
    capture_frame("lz_0050");
    for (int i = 0; i < 16; i++) begin
      ea = ev[(i/4)*4 +: 4];
      ed = exp_dn(i, 4'b0011);
      n_tests++;
      if (obs_addr[i] !== ea || obs_dn[i] !== ed || obs_fs[i] !== (i == 0)) begin
        n_fail++;
        $display("FAIL lz_0050 cyc%0d: addr=%h dn=%b fs=%b, expected addr=%h dn=%b fs=%b", i, obs_addr[i], obs_dn[i], obs_fs[i], ea, ed, i == 0);
      end
    end
    ev = 16'h0000;
    tick();
    value = ev; load = 1'b1;
    tick();
    load = 1'b0;
    capture_frame("lz_0000");
    for (int i = 0; i < 16; i++) begin
      ed = exp_dn(i, 4'b0001);
      n_tests++;
      if (obs_addr[i] !== 4'h0 || obs_dn[i] !== ed || obs_fs[i] !== (i == 0)) begin
        n_fail++;
        $display("FAIL lz_0000 cyc%0d: addr=%h dn=%b fs=%b, expected addr=0 dn=%b fs=%b", i, obs_addr[i], obs_dn[i], obs_fs[i], ed, i == 0);
      end
    end
    lz_en = 1'b0;
  endtask

  task automatic test_midframe_load();
    logic [15:0] ev;
    logic [3:0] ea, ed;
    ev = 16'hABCD;
    tick();
    repeat (4) tick();
    value = ev; load = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 5; i < 16; i++) begin
      ed = exp_dn(i, 4'b1111);
      n_tests++;
      if (address !== 4'h0 || digit_n !== ed || frame_start !== 1'b0) begin
        n_fail++;
        $display("FAIL midframe_old cyc%0d: addr=%h dn=%b fs=%b, expected addr=0 dn=%b fs=0", i, address, digit_n, frame_start, ed);
      end
      if (i < 15) tick();
    end
    capture_frame("midframe_new");
    for (int i = 0; i < 16; i++) begin
      ea = ev[(i/4)*4 +: 4];
      ed = exp_dn(i, 4'b1111);
      n_tests++;
      if (obs_addr[i] !== ea || obs_dn[i] !== ed || obs_fs[i] !== (i == 0)) begin
        n_fail++;
        $display("FAIL midframe_new cyc%0d: addr=%h dn=%b fs=%b, expected addr=%h dn=%b fs=%b", i, obs_addr[i], obs_dn[i], obs_fs[i], ea, ed, i == 0);
      end
    end
  endtask

  task automatic test_boundary_load();
    logic [15:0] ev_old, ev_new;
    logic [3:0] ea, ed;
    ev_old = 16'hABCD;
    ev_new = 16'h5A5A;
    value = ev_new; load = 1'b1;
    tick();
    load = 1'b0;
    capture_frame("boundary_same");
    for (int i = 0; i < 16; i++) begin
      ea = ev_old[(i/4)*4 +: 4];
      ed = exp_dn(i, 4'b1111);
      n_tests++;
      if (obs_addr[i] !== ea || obs_dn[i] !== ed || obs_fs[i] !== (i == 0)) begin
        n_fail++;
        $display("FAIL boundary_same cyc%0d: addr=%h dn=%b fs=%b, expected addr=%h dn=%b fs=%b", i, obs_addr[i], obs_dn[i], obs_fs[i], ea, ed, i == 0);
      end
    end
    capture_frame("boundary_next");
    for (int i = 0; i < 16; i++) begin
      ea = ev_new[(i/4)*4 +: 4];
      ed = exp_dn(i, 4'b1111);
      n_tests++;
      if (obs_addr[i] !== ea || obs_dn[i] !== ed || obs_fs[i] !== (i == 0)) begin
        n_fail++;
        $display("FAIL boundary_next cyc%0d: addr=%h dn=%b fs=%b, expected addr=%h dn=%b fs=%b", i, obs_addr[i], obs_dn[i], obs_fs[i], ea, ed, i == 0);
      end
    end
  endtask

  task automatic test_blank();
    logic [3:0] ed;
    blank = 4'b0100;
    tick();
    value = 16'h8888; load = 1'b1;
    tick();
    load = 1'b0;
    capture_frame("blank");
    for (int i = 0; i < 16; i++) begin
      ed = exp_dn(i, 4'b1011);
      n_tests++;
      if (obs_addr[i] !== 4'h8 || obs_dn[i] !== ed || obs_fs[i] !== (i == 0)) begin
        n_fail++;
        $display("FAIL blank cyc%0d: addr=%h dn=%b fs=%b, expected addr=8 dn=%b fs=%b", i, obs_addr[i], obs_dn[i], obs_fs[i], ed, i == 0);
      end
    end
    tick();
    n_tests++;
    if (frame_start !== 1'b1) begin
      n_fail++;
      $display("FAIL blank_period16: fs=%b at cycle 16, expected 1", frame_start);
    end
  endtask

  task automatic test_reset_midslot();
    logic [3:0] ed;
    blank = 4'b0000;
    repeat (9) tick();
    value = 16'hFFFF; load = 1'b1;
    tick();
    load = 1'b0;
    n_tests++;
    if (address !== 4'h8 || digit_n !== 4'b1011 || frame_start !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_pre: addr=%h dn=%b fs=%b, expected addr=8 dn=1011 fs=0", address, digit_n, frame_start);
    end
    reset = 1'b1;
    #2;
    n_tests++;
    if (address !== 4'h0 || digit_n !== 4'b1111 || frame_start !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_async: addr=%h dn=%b fs=%b, expected addr=0 dn=1111 fs=0", address, digit_n, frame_start);
    end
    tick();
    reset = 1'b0;
    tick();
    n_tests++;
    if (frame_start !== 1'b1 || address !== 4'h0) begin
      n_fail++;
      $display("FAIL rst_mid_release: fs=%b addr=%h, expected fs=1 addr=0", frame_start, address);
    end
    capture_frame("rst_mid_f1");
    for (int i = 0; i < 16; i++) begin
      ed = exp_dn(i, 4'b1111);
      n_tests++;
      if (obs_addr[i] !== 4'h0 || obs_dn[i] !== ed || obs_fs[i] !== (i == 0)) begin
        n_fail++;
        $display("FAIL rst_mid_f1 cyc%0d: addr=%h dn=%b fs=%b, expected addr=0 dn=%b fs=%b", i, obs_addr[i], obs_dn[i], obs_fs[i], ed, i == 0);
      end
    end
    capture_frame("rst_mid_f2");
    for (int i = 0; i < 16; i++) begin
      ed = exp_dn(i, 4'b1111);
      n_tests++;
      if (obs_addr[i] !== 4'h0 || obs_dn[i] !== ed || obs_fs[i] !== (i == 0)) begin
        n_fail++;
        $display("FAIL rst_mid_f2 cyc%0d: addr=%h dn=%b fs=%b, expected addr=0 dn=%b fs=%b", i, obs_addr[i], obs_dn[i], obs_fs[i], ed, i == 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_leading_zero();
    test_midframe_load();
    test_boundary_load();
    test_blank();
    test_reset_midslot();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
